// File: rtl/bus_uart_tx_if.sv
// Peripheral-bus write channel between the CPU store path and bus_uart_tx.
//   bus_din          write data (CPU bus_dout)
//   bus_addr         write address
//   bus_write_valid  write request, held with stable addr/data until accepted
//   bus_write_ready  responder ready; a write completes on valid && ready
// master: CPU side.  slave: UART transmitter side.
interface bus_uart_tx_if;
  logic [31:0] bus_din;
  logic [31:0] bus_addr;
  logic        bus_write_valid;
  logic        bus_write_ready;

  modport master (
    output bus_din,
    output bus_addr,
    output bus_write_valid,
    input  bus_write_ready
  );

  modport slave (
    input  bus_din,
    input  bus_addr,
    input  bus_write_valid,
    output bus_write_ready
  );
endinterface

// File: rtl/bus_uart_tx.sv
// Memory-mapped UART transmitter, write responder for the 0xE address region.
// Bytes written to TXDATA are buffered in a FIFO and sent 8N1 on uart_tx.
// Back-pressure (bus_write_ready=0) only when a TXDATA write meets a full FIFO.
//
// Register map (selected when bus_addr[31:28]==4'hE, register = bus_addr[3:2]):
//   0 TXDATA  push bus_din[7:0]
//   1 DIV     bit-period divisor <= bus_din[15:0] (values below 2 stored as 2)
//   2,3       accepted and ignored
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous, active-high
//   bus         bus_uart_tx_if.slave write channel
//   uart_tx     serial line, idle high, registered
//   tx_busy     FSM not idle or FIFO non-empty
//   fifo_count  current FIFO occupancy
//
// Optional build macro: BUS_UART_TX_PARITY_EN inserts an even-parity bit
// between the data bits and the stop bit (11-bit frames).
module bus_uart_tx #(
  parameter int unsigned CLK_DIV    = 868,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  bus_uart_tx_if.slave                bus,
  output logic                        uart_tx,
  output logic                        tx_busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

`ifdef BUS_UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;
`else
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;
`endif

  state_e state_q, state_d;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] fifo_count_q, fifo_count_d;
  logic [7:0]       mem_q [FIFO_DEPTH];

  logic [15:0] div_q, div_d;
  logic [15:0] bit_div_q, bit_div_d;
  logic [15:0] timer_q, timer_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        uart_tx_q, uart_tx_d;
`ifdef BUS_UART_TX_PARITY_EN
  logic        parity_q, parity_d;
`endif

  logic       sel;
  logic [1:0] reg_sel;
  logic       fifo_full;
  logic       fifo_empty;
  logic       accept;
  logic       push;
  logic       pop;
  logic       div_wr;
  logic       bit_done;
  logic [7:0] pop_data;

  // Address bits outside the decode and data bits above the DIV field.
  logic unused_bits;
  assign unused_bits = ^{bus.bus_din[31:16], bus.bus_addr[27:4], bus.bus_addr[1:0]};

  // ---------------------------------------------------------------------------
  // Bus decode and handshake
  // ---------------------------------------------------------------------------
  assign sel        = (bus.bus_addr[31:28] == 4'hE);
  assign reg_sel    = bus.bus_addr[3:2];
  assign fifo_full  = (fifo_count_q == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (fifo_count_q == '0);

  // Ready never looks at valid, so the CPU side can use it without a loop.
  assign bus.bus_write_ready = !(sel && (reg_sel == 2'd0) && fifo_full);

  assign accept = bus.bus_write_valid && bus.bus_write_ready;
  assign push   = accept && sel && (reg_sel == 2'd0);
  assign div_wr = accept && sel && (reg_sel == 2'd1);

  assign bit_done = (timer_q == '0);
  assign pop_data = mem_q[rd_ptr_q];

  // ---------------------------------------------------------------------------
  // FIFO pointers/occupancy and divisor register
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    fifo_count_d = fifo_count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   fifo_count_d = fifo_count_q + CNT_W'(1);
      2'b01:   fifo_count_d = fifo_count_q - CNT_W'(1);
      default: fifo_count_d = fifo_count_q;
    endcase
  end

  always_comb begin
    div_d = div_q;
    if (div_wr) begin
      div_d = (bus.bus_din[15:0] < 16'd2) ? 16'd2 : bus.bus_din[15:0];
    end
  end

  // Storage needs no reset: the pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.bus_din[7:0];
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_count_q <= '0;
      div_q        <= 16'(CLK_DIV);
      bit_div_q    <= 16'(CLK_DIV);
      timer_q      <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      uart_tx_q    <= 1'b1;
`ifdef BUS_UART_TX_PARITY_EN
      parity_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fifo_count_q <= fifo_count_d;
      div_q        <= div_d;
      bit_div_q    <= bit_div_d;
      timer_q      <= timer_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      uart_tx_q    <= uart_tx_d;
`ifdef BUS_UART_TX_PARITY_EN
      parity_q     <= parity_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (!fifo_empty) state_d = S_START;
      S_START: if (bit_done) state_d = S_DATA;
      S_DATA: begin
        if (bit_done && (bit_idx_q == 3'd7)) begin
`ifdef BUS_UART_TX_PARITY_EN
          state_d = S_PARITY;
`else
          state_d = S_STOP;
`endif
        end
      end
`ifdef BUS_UART_TX_PARITY_EN
      S_PARITY: if (bit_done) state_d = S_STOP;
`endif
      // Last stop cycle chains straight into the next START when data waits.
      S_STOP:  if (bit_done) state_d = fifo_empty ? S_IDLE : S_START;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs and datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    pop       = ((state_q == S_IDLE) || ((state_q == S_STOP) && bit_done)) && !fifo_empty;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    timer_d   = timer_q;
    bit_div_d = bit_div_q;
`ifdef BUS_UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif

    if (pop) begin
      // Frame start: the divisor is captured here so DIV writes only
      // affect frames that have not started yet.
      shift_d   = pop_data;
      bit_div_d = div_q;
      timer_d   = div_q - 16'd1;
      bit_idx_d = '0;
`ifdef BUS_UART_TX_PARITY_EN
      parity_d  = ^pop_data;
`endif
    end else if (state_q != S_IDLE) begin
      if (bit_done) begin
        timer_d = bit_div_q - 16'd1;
        if (state_q == S_START) bit_idx_d = '0;
        if (state_q == S_DATA) begin
          bit_idx_d = bit_idx_q + 3'd1;
          shift_d   = shift_q >> 1;
        end
      end else begin
        timer_d = timer_q - 16'd1;
      end
    end

    // Line level is registered from the state being entered, so it changes
    // on the same edge as the state.
    case (state_d)
      S_START:  uart_tx_d = 1'b0;
      S_DATA:   uart_tx_d = shift_d[0];
`ifdef BUS_UART_TX_PARITY_EN
      S_PARITY: uart_tx_d = parity_d;
`endif
      default:  uart_tx_d = 1'b1;
    endcase
  end

  assign uart_tx    = uart_tx_q;
  assign tx_busy    = (state_q != S_IDLE) || !fifo_empty;
  assign fifo_count = fifo_count_q;

endmodule

// File: tb/tb_bus_uart_tx.sv
module tb_bus_uart_tx;

`ifdef BUS_UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int DIV0 = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       uart_tx;
  logic       tx_busy;
  logic [2:0] fifo_count;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int acc_cyc = -1;
  int p;

  bus_uart_tx_if bus ();

  bus_uart_tx #(.CLK_DIV(DIV0), .FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .uart_tx    (uart_tx),
    .tx_busy    (tx_busy),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; sampling happens 1ns after the rising edge. A write that is
  // valid and ready before the edge is counted as accepted and released.
  task automatic tick();
    logic acc;
    acc = bus.bus_write_valid && bus.bus_write_ready && !reset;
    @(posedge clk);
    #1;
    cyc++;
    if (acc) begin
      bus.bus_write_valid = 1'b0;
      acc_cyc = cyc;
    end
  endtask

  task automatic wait_idle(input string tag, input int limit);
    int n;
    n = 0;
    while (tx_busy && (n < limit)) begin
      tick();
      n++;
    end
    if (tx_busy) begin
      checks++;
      errors++;
      $error("FAIL %s: timed out after %0d cycles waiting for idle", tag, limit);
    end else begin
      check(tag, tx_busy, 1'b0);
    end
  endtask

  task automatic post(input logic [31:0] a, input logic [31:0] d);
    bus.bus_addr        = a;
    bus.bus_din         = d;
    bus.bus_write_valid = 1'b1;
    #1;
  endtask

  function automatic logic exp_bit(input logic [7:0] b, input int pos);
    if (pos == 0) return 1'b0;
    if (pos <= 8) return b[pos-1];
`ifdef BUS_UART_TX_PARITY_EN
    if (pos == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  // Checks the line every cycle of a frame whose pop edge was 'start'.
  task automatic check_stream(input logic [7:0] b, input int start, input int div,
                              input string tag);
    while (cyc < start) tick();
    while (cyc < start + div * NBITS) begin
      check(tag, uart_tx, exp_bit(b, (cyc - start) / div));
      tick();
    end
  endtask

  initial begin
    bus.bus_addr        = '0;
    bus.bus_din         = '0;
    bus.bus_write_valid = 1'b0;

    // Reset / idle
    repeat (3) tick();
    check("rst_uart_tx", uart_tx, 1'b1);
    check("rst_ready", bus.bus_write_ready, 1'b1);
    check("rst_busy", tx_busy, 1'b0);
    check("rst_count", fifo_count, 3'd0);
    reset = 1'b0;
    tick();
    check("idle_uart_tx", uart_tx, 1'b1);

    // Single byte 0x55: count 1 after accept, pop one edge later
    post(32'hE000_0000, 32'h55);
    tick();
    check("w55_count_after_accept", fifo_count, 3'd1);
    check("w55_line_before_pop", uart_tx, 1'b1);
    check("w55_busy", tx_busy, 1'b1);
    tick();
    p = cyc;
    check("w55_count_after_pop", fifo_count, 3'd0);
    check_stream(8'h55, p, DIV0, "w55_bit");
    check("w55_busy_end", tx_busy, 1'b0);
    check("w55_frame_len", cyc - p, DIV0 * NBITS);

    // Unselected and ignored registers: accepted, no action
    post(32'h1000_0000, 32'h99);
    check("unsel_ready", bus.bus_write_ready, 1'b1);
    tick();
    check("unsel_accepted", bus.bus_write_valid, 1'b0);
    post(32'hE000_0008, 32'h98);
    tick();
    post(32'hE000_000C, 32'h0001);
    tick();
    tick();
    check("ign_count", fifo_count, 3'd0);
    check("ign_line", uart_tx, 1'b1);
    check("ign_busy", tx_busy, 1'b0);

    // Back-pressure with depth 4: six writes 0x01..0x06
    post(32'hE000_0000, 32'h01);
    tick();
    post(32'hE000_0000, 32'h02);
    tick();
    p = cyc;
    check("bp_count_after_pop", fifo_count, 3'd1);
    check("bp_first_start", uart_tx, 1'b0);
    post(32'hE000_0000, 32'h03);
    tick();
    post(32'hE000_0000, 32'h04);
    tick();
    post(32'hE000_0000, 32'h05);
    tick();
    check("bp_full_count", fifo_count, 3'd4);
    post(32'hE000_0000, 32'h06);
    check("bp_full_ready", bus.bus_write_ready, 1'b0);
    post(32'hE000_0004, 32'h0004);
    check("bp_full_div_ready", bus.bus_write_ready, 1'b1);
    post(32'hE000_0000, 32'h06);
    check_stream(8'h01, p, DIV0, "bp_f1_bit");
    check("bp_count_after_pop2", fifo_count, 3'd3);
    check("bp_ready_after_pop", bus.bus_write_ready, 1'b1);
    check("bp_still_pending", bus.bus_write_valid, 1'b1);
    check_stream(8'h02, p + DIV0 * NBITS, DIV0, "bp_f2_bit");
    check("bp_accept_cycle", acc_cyc - p, DIV0 * NBITS + 1);
    check_stream(8'h03, p + 2 * DIV0 * NBITS, DIV0, "bp_f3_bit");
    check_stream(8'h04, p + 3 * DIV0 * NBITS, DIV0, "bp_f4_bit");
    check_stream(8'h05, p + 4 * DIV0 * NBITS, DIV0, "bp_f5_bit");
    check_stream(8'h06, p + 5 * DIV0 * NBITS, DIV0, "bp_f6_bit");
    check("bp_busy_end", tx_busy, 1'b0);
    check("bp_count_end", fifo_count, 3'd0);

    // Divisor write mid-frame applies to the next frame only
    post(32'hE000_0000, 32'h41);
    tick();
    tick();
    p = cyc;
    post(32'hE000_0004, 32'h0008);
    tick();
    post(32'hE000_0000, 32'h42);
    tick();
    check_stream(8'h41, p, DIV0, "div_old_bit");
    check_stream(8'h42, p + DIV0 * NBITS, 8, "div_new_bit");
    check("div_busy_end", tx_busy, 1'b0);

    // Divisor 0 is stored as 2
    post(32'hE000_0004, 32'h0000);
    tick();
    post(32'hE000_0000, 32'h5A);
    tick();
    tick();
    p = cyc;
    check_stream(8'h5A, p, 2, "div_min_bit");
    check("div_min_busy_end", tx_busy, 1'b0);
    post(32'hE000_0004, DIV0);
    tick();

    // Reset during DATA bit 3, with a second byte queued
    post(32'hE000_0000, 32'h33);
    tick();
    tick();
    p = cyc;
    post(32'hE000_0000, 32'h44);
    tick();
    while (cyc < p + 4 * DIV0 + 1) tick();
    check("rmid_bit3_low", uart_tx, 1'b0);
    check("rmid_count_before", fifo_count, 3'd1);
    reset = 1'b1;
    #1;
    check("rmid_async_line", uart_tx, 1'b1);
    check("rmid_count", fifo_count, 3'd0);
    check("rmid_busy", tx_busy, 1'b0);
    post(32'hE000_0000, 32'h5C);
    tick();
    tick();
    check("rmid_held_not_taken", fifo_count, 3'd0);
    check("rmid_held_pending", bus.bus_write_valid, 1'b1);
    reset = 1'b0;
    tick();
    check("rmid_taken_after_release", fifo_count, 3'd1);
    tick();
    p = cyc;
    check_stream(8'h5C, p, DIV0, "rmid_clean_bit");
    check("rmid_busy_end", tx_busy, 1'b0);

`ifdef BUS_UART_TX_PARITY_EN
    // Parity bit for 0x07 is 1; frame is 11 bit periods
    post(32'hE000_0000, 32'h07);
    tick();
    tick();
    p = cyc;
    while (cyc < p + 9 * DIV0) tick();
    check("par_bit", uart_tx, 1'b1);
    check_stream(8'h07, p, DIV0, "par_frame_bit");
    check("par_busy_end", tx_busy, 1'b0);
    check("par_frame_len", cyc - p, 44);
`endif

    wait_idle("final_idle_wait", 20 * DIV0 * NBITS);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
